dtcm_port_arbiter: RTL and testbench

//  Shares the single DTCM port between two requesters: core data side (dmem_ctrl, port C) and system DMA/debug (port S).

---
 rtl/dtcm_port_arbiter_pkg.sv | 16 +
 rtl/dtcm_port_arbiter_tag_fifo.sv | 50 +++++
 rtl/dtcm_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_dtcm_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtcm_port_arbiter_pkg.sv
// Shared constants and types for the DTCM port arbiter: bus widths, owner tags and arbitration states.
package dtcm_port_arbiter_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned DTCM_SIZE  = 65536;
  localparam int unsigned ADDR_WIDTH = $clog2(DTCM_SIZE);

  typedef enum logic {
    ARB_CORE_PRI = 1'b0,
    ARB_S_PRI    = 1'b1
  } arb_state_e;

  localparam logic TAG_C = 1'b0;
  localparam logic TAG_S = 1'b1;

endpackage

// File: rtl/dtcm_port_arbiter_tag_fifo.sv
// In-order FIFO of 1-bit read-owner tags; DEPTH must be a power of 2.
module arb_tag_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic cpu_clk,
  input  logic cpu_rstn,
  input  logic i_push,
  input  logic i_push_tag,
  input  logic i_pop,
  output logic o_full,
  output logic o_empty,
  output logic o_head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_tag;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (!w_push && w_pop) r_count <= r_count - CNT_ONE;
    end
  end

endmodule

// File: rtl/dtcm_port_arbiter.sv
// Two-requester DTCM port arbiter (core C, system S) with in-order read-return routing.
// Define KRV_DTCM_ARB_BOOST_EN to add the S anti-starvation boost FSM.
module dtcm_port_arbiter
  import dtcm_port_arbiter_pkg::*;
#(
  parameter int unsigned TAG_DEPTH = 2
`ifdef KRV_DTCM_ARB_BOOST_EN
  , parameter int unsigned WAIT_LIMIT = 8
`endif
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  c_access,
  input  logic                  c_rd0_wr1,
  input  logic [3:0]            c_byte_strobe,
  input  logic [DATA_WIDTH-1:0] c_write_data,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  output logic                  c_ready,
  output logic [DATA_WIDTH-1:0] c_read_data,
  output logic                  c_read_data_valid,
  input  logic                  s_access,
  input  logic                  s_rd0_wr1,
  input  logic [3:0]            s_byte_strobe,
  input  logic [DATA_WIDTH-1:0] s_write_data,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] s_read_data,
  output logic                  s_read_data_valid,
  output logic                  dtcm_access,
  input  logic                  dtcm_ready,
  output logic                  dtcm_rd0_wr1,
  output logic [3:0]            dtcm_byte_strobe,
  output logic [DATA_WIDTH-1:0] dtcm_write_data,
  output logic [ADDR_WIDTH-1:0] dtcm_addr,
  input  logic [DATA_WIDTH-1:0] dtcm_read_data,
  input  logic                  dtcm_read_data_valid,
  output logic                  arb_busy
);

  arb_state_e w_state;
  logic       w_grant_c;
  logic       w_grant_s;
  logic       w_rd;
  logic       w_block;
  logic       w_full;
  logic       w_empty;
  logic       w_head;
  logic       w_push;
  logic       w_pop;

  always_comb begin
    w_grant_c = c_access && ((w_state == ARB_CORE_PRI) || !s_access);
    w_grant_s = s_access && !w_grant_c;
    w_rd      = w_grant_c ? !c_rd0_wr1 : (w_grant_s && !s_rd0_wr1);
    w_block   = w_rd && w_full;
  end

  always_comb begin
    dtcm_rd0_wr1     = 1'b0;
    dtcm_byte_strobe = '0;
    dtcm_write_data  = '0;
    dtcm_addr        = '0;
    if (w_grant_c) begin
      dtcm_rd0_wr1     = c_rd0_wr1;
      dtcm_byte_strobe = c_byte_strobe;
      dtcm_write_data  = c_write_data;
      dtcm_addr        = c_addr;
    end else if (w_grant_s) begin
      dtcm_rd0_wr1     = s_rd0_wr1;
      dtcm_byte_strobe = s_byte_strobe;
      dtcm_write_data  = s_write_data;
      dtcm_addr        = s_addr;
    end
  end

  assign dtcm_access = (w_grant_c || w_grant_s) && !w_block;
  assign c_ready     = w_grant_c && dtcm_ready && !w_block;
  assign s_ready     = w_grant_s && dtcm_ready && !w_block;

  assign w_push = (c_access && c_ready && !c_rd0_wr1) ||
                  (s_access && s_ready && !s_rd0_wr1);
  assign w_pop  = dtcm_read_data_valid && !w_empty;

  arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .cpu_clk    (cpu_clk),
    .cpu_rstn   (cpu_rstn),
    .i_push     (w_push),
    .i_push_tag (w_grant_s ? TAG_S : TAG_C),
    .i_pop      (w_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head     (w_head)
  );

  // A return with no tag outstanding is dropped (e.g. from a read issued before reset).
  assign c_read_data_valid = w_pop && (w_head == TAG_C);
  assign s_read_data_valid = w_pop && (w_head == TAG_S);
  assign c_read_data       = c_read_data_valid ? dtcm_read_data : '0;
  assign s_read_data       = s_read_data_valid ? dtcm_read_data : '0;
  assign arb_busy          = !w_empty;

`ifdef KRV_DTCM_ARB_BOOST_EN
  localparam int unsigned CW = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_LIMIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic [CW-1:0] r_wait_cnt;
  logic          w_s_accept;
  logic          w_s_refused;

  assign w_s_accept  = s_access && s_ready;
  assign w_s_refused = s_access && !s_ready;

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_state    <= ARB_CORE_PRI;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_s_accept)
        r_wait_cnt <= '0;
      else if (w_s_refused && (r_wait_cnt != CNT_MAX))
        r_wait_cnt <= r_wait_cnt + CNT_ONE;
    end
  end

  // Counter saturates at the trigger value so a dropped-and-reraised S re-boosts on its next refusal.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_CORE_PRI: if (w_s_refused && (r_wait_cnt == CNT_MAX)) w_state_nxt = ARB_S_PRI;
      ARB_S_PRI:    if (w_s_accept || !s_access)                w_state_nxt = ARB_CORE_PRI;
      default:      w_state_nxt = ARB_CORE_PRI;
    endcase
  end

  assign w_state = r_state;
`else
  assign w_state = ARB_CORE_PRI;
`endif

`ifndef SYNTHESIS
  logic r_seen_rd;

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn)   r_seen_rd <= 1'b0;
    else if (w_push) r_seen_rd <= 1'b1;
  end

  a_no_orphan_return: assert property (@(posedge cpu_clk) disable iff (!cpu_rstn)
    !(dtcm_read_data_valid && w_empty && r_seen_rd));
`endif

endmodule

// File: tb/tb_dtcm_port_arbiter.sv
// Self-checking bench for dtcm_port_arbiter: vector table, directed corner sequences and a random run.
module tb_dtcm_port_arbiter;
  import dtcm_port_arbiter_pkg::*;

  localparam int unsigned TD = 2;
  localparam int unsigned WL = 8;

  logic                  cpu_clk = 1'b0;
  logic                  cpu_rstn;
  logic                  c_access, c_rd0_wr1, s_access, s_rd0_wr1;
  logic [3:0]            c_byte_strobe, s_byte_strobe, dtcm_byte_strobe;
  logic [DATA_WIDTH-1:0] c_write_data, s_write_data, dtcm_write_data;
  logic [ADDR_WIDTH-1:0] c_addr, s_addr, dtcm_addr;
  logic                  c_ready, s_ready, c_read_data_valid, s_read_data_valid;
  logic [DATA_WIDTH-1:0] c_read_data, s_read_data, dtcm_read_data;
  logic                  dtcm_access, dtcm_ready, dtcm_rd0_wr1, dtcm_read_data_valid, arb_busy;

  dtcm_port_arbiter #(
    .TAG_DEPTH(TD)
`ifdef KRV_DTCM_ARB_BOOST_EN
    , .WAIT_LIMIT(WL)
`endif
  ) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
    .c_access(c_access), .c_rd0_wr1(c_rd0_wr1), .c_byte_strobe(c_byte_strobe),
    .c_write_data(c_write_data), .c_addr(c_addr), .c_ready(c_ready),
    .c_read_data(c_read_data), .c_read_data_valid(c_read_data_valid),
    .s_access(s_access), .s_rd0_wr1(s_rd0_wr1), .s_byte_strobe(s_byte_strobe),
    .s_write_data(s_write_data), .s_addr(s_addr), .s_ready(s_ready),
    .s_read_data(s_read_data), .s_read_data_valid(s_read_data_valid),
    .dtcm_access(dtcm_access), .dtcm_ready(dtcm_ready), .dtcm_rd0_wr1(dtcm_rd0_wr1),
    .dtcm_byte_strobe(dtcm_byte_strobe), .dtcm_write_data(dtcm_write_data),
    .dtcm_addr(dtcm_addr), .dtcm_read_data(dtcm_read_data),
    .dtcm_read_data_valid(dtcm_read_data_valid), .arb_busy(arb_busy)
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue of outstanding read owners (0=C, 1=S) and S-boost bookkeeping.
  bit q_own[$];
  bit m_boost;
  int m_ref;
  bit m_c_acc, m_s_acc;
  bit act_s_rdy;

  typedef struct {
    logic ca, cw, sa, sw, dr;
    logic e_cr, e_sr, e_dacc, e_dwr;
    logic [1:0] src;
  } vec_t;

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    c_access = 0; c_rd0_wr1 = 0; c_byte_strobe = '0; c_write_data = '0; c_addr = '0;
    s_access = 0; s_rd0_wr1 = 0; s_byte_strobe = '0; s_write_data = '0; s_addr = '0;
    dtcm_ready = 1; dtcm_read_data = '0; dtcm_read_data_valid = 0;
  endtask

  function automatic logic [127:0] all_outs();
    return {c_ready, s_ready, c_read_data, s_read_data, c_read_data_valid, s_read_data_valid,
            dtcm_access, dtcm_rd0_wr1, dtcm_byte_strobe, dtcm_write_data, dtcm_addr, arb_busy};
  endfunction

  // Called at a negedge after inputs are driven; checks outputs, advances one clock, ends at negedge.
  task automatic cycle_model();
    logic gc, gs, rd, blk, ecr, esr, edacc, pop, head;
    logic [52:0] ecmd;
    int sz;
    #1;
    sz    = q_own.size();
    gc    = c_access && (!m_boost || !s_access);
    gs    = s_access && !gc;
    rd    = gc ? !c_rd0_wr1 : (gs && !s_rd0_wr1);
    blk   = rd && (sz == TD);
    edacc = (gc || gs) && !blk;
    ecr   = gc && dtcm_ready && !blk;
    esr   = gs && dtcm_ready && !blk;
    ecmd  = gc ? {c_rd0_wr1, c_byte_strobe, c_write_data, c_addr} :
            gs ? {s_rd0_wr1, s_byte_strobe, s_write_data, s_addr} : '0;
    pop   = dtcm_read_data_valid && (sz > 0);
    head  = (sz > 0) ? q_own[0] : 1'b0;
    cmp("ready", {c_ready, s_ready, dtcm_access}, {ecr, esr, edacc});
    cmp("dtcm_cmd", {dtcm_rd0_wr1, dtcm_byte_strobe, dtcm_write_data, dtcm_addr}, ecmd);
    cmp("c_rdata", {c_read_data_valid, c_read_data}, (pop && !head) ? {1'b1, dtcm_read_data} : 33'd0);
    cmp("s_rdata", {s_read_data_valid, s_read_data}, (pop && head) ? {1'b1, dtcm_read_data} : 33'd0);
    cmp("busy", arb_busy, sz > 0);
    act_s_rdy = s_ready;
    m_c_acc = c_access && ecr;
    m_s_acc = s_access && esr;
    @(posedge cpu_clk);
    if (pop) void'(q_own.pop_front());
    if (m_c_acc && !c_rd0_wr1) q_own.push_back(1'b0);
    if (m_s_acc && !s_rd0_wr1) q_own.push_back(1'b1);
`ifdef KRV_DTCM_ARB_BOOST_EN
    if (m_s_acc) begin
      m_ref = 0; m_boost = 0;
    end else begin
      if (m_boost && !s_access) m_boost = 0;
      if (s_access) begin
        m_ref++;
        if (m_ref >= WL) m_boost = 1;
      end
    end
`endif
    @(negedge cpu_clk);
  endtask

  task automatic drain();
    while (q_own.size() > 0) begin
      idle();
      dtcm_read_data_valid = 1;
      dtcm_read_data = $urandom;
      cycle_model();
    end
    idle();
  endtask

  task automatic model_reset();
    q_own.delete();
    m_boost = 0; m_ref = 0; m_c_acc = 0; m_s_acc = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[10];
    int got, busy_n;

    vt[0] = '{0,0,0,0,1, 0,0,0,0, 2'd0};
    vt[1] = '{1,0,0,0,1, 1,0,1,0, 2'd1};
    vt[2] = '{1,1,0,0,1, 1,0,1,1, 2'd1};
    vt[3] = '{0,0,1,0,1, 0,1,1,0, 2'd2};
    vt[4] = '{0,0,1,1,1, 0,1,1,1, 2'd2};
    vt[5] = '{1,1,1,0,1, 1,0,1,1, 2'd1};
    vt[6] = '{1,0,1,1,1, 1,0,1,0, 2'd1};
    vt[7] = '{1,0,0,0,0, 0,0,1,0, 2'd1};
    vt[8] = '{0,0,1,1,0, 0,0,1,1, 2'd2};
    vt[9] = '{1,1,1,1,0, 0,0,1,1, 2'd1};

    model_reset();
    idle();
    cpu_rstn = 0;
    repeat (2) @(negedge cpu_clk);
    cmp("reset_outs", all_outs(), '0);
    cpu_rstn = 1;
    @(negedge cpu_clk);

    // Vector table: each applied with an empty tag FIFO.
    for (int i = 0; i < 10; i++) begin
      idle();
      c_access = vt[i].ca; c_rd0_wr1 = vt[i].cw; c_addr = ADDR_WIDTH'(16'h1000 + i);
      s_access = vt[i].sa; s_rd0_wr1 = vt[i].sw; s_addr = ADDR_WIDTH'(16'h2000 + i);
      dtcm_ready = vt[i].dr;
      #1;
      cmp("tbl_ready", {c_ready, s_ready, dtcm_access, dtcm_rd0_wr1},
          {vt[i].e_cr, vt[i].e_sr, vt[i].e_dacc, vt[i].e_dwr});
      cmp("tbl_addr", dtcm_addr, (vt[i].src == 2'd1) ? ADDR_WIDTH'(16'h1000 + i) :
                                 (vt[i].src == 2'd2) ? ADDR_WIDTH'(16'h2000 + i) : '0);
      cycle_model();
      drain();
    end

    // 1: lone C read, data next cycle.
    idle(); c_access = 1; c_addr = 16'h0010;
    #1 cmp("t1_c_ready", c_ready, 1'b1);
    cycle_model();
    idle(); dtcm_read_data_valid = 1; dtcm_read_data = 32'hA5A5_0001;
    #1 cmp("t1_rdata", {c_read_data_valid, c_read_data, s_read_data_valid}, {1'b1, 32'hA5A5_0001, 1'b0});
    cycle_model();

    // 2: C write and S read together.
    idle(); c_access = 1; c_rd0_wr1 = 1; c_addr = 16'h0020; s_access = 1; s_addr = 16'h0030;
    #1 cmp("t2_cyc0", {c_ready, s_ready}, 2'b10);
    cycle_model();
    c_access = 0;
    #1 cmp("t2_cyc1", {c_ready, s_ready}, 2'b01);
    cycle_model();
    idle(); dtcm_read_data_valid = 1; dtcm_read_data = 32'hBEEF_0002;
    #1 cmp("t2_rdata", {s_read_data_valid, s_read_data, c_read_data_valid}, {1'b1, 32'hBEEF_0002, 1'b0});
    cycle_model();

    // 3: C read then S read back-to-back, in-order returns.
    busy_n = 0;
    idle(); c_access = 1; c_addr = 16'h0040;
    cycle_model(); busy_n += int'(arb_busy);
    idle(); s_access = 1; s_addr = 16'h0044; dtcm_read_data_valid = 1; dtcm_read_data = 32'h0000_1111;
    #1 cmp("t3_ret_c", {c_read_data_valid, c_read_data, s_read_data_valid}, {1'b1, 32'h0000_1111, 1'b0});
    cycle_model(); busy_n += int'(arb_busy);
    idle(); dtcm_read_data_valid = 1; dtcm_read_data = 32'h0000_2222;
    #1 cmp("t3_ret_s", {s_read_data_valid, s_read_data, c_read_data_valid}, {1'b1, 32'h0000_2222, 1'b0});
    cycle_model(); busy_n += int'(arb_busy);
    idle();
    cycle_model(); busy_n += int'(arb_busy);
    cmp("t3_busy_cycles", 128'(busy_n), 128'd2);

    // 4: FIFO full gates a third read until after the first return.
    idle(); c_access = 1; c_addr = 16'h0050;
    cycle_model();
    c_addr = 16'h0054;
    cycle_model();
    c_addr = 16'h0058;
    for (int k = 0; k < 2; k++) begin
      #1 cmp("t4_blocked", {c_ready, dtcm_access}, 2'b00);
      cycle_model();
    end
    dtcm_read_data_valid = 1; dtcm_read_data = 32'h0000_3333;
    #1 cmp("t4_ret_cycle", {c_ready, dtcm_access, c_read_data_valid}, 3'b001);
    cycle_model();
    dtcm_read_data_valid = 0;
    #1 cmp("t4_resume", {c_ready, dtcm_access}, 2'b11);
    cycle_model();
    drain();

    // 6: reset with two reads outstanding; stray return afterwards is ignored.
    idle(); c_access = 1; c_addr = 16'h0060;
    cycle_model();
    c_addr = 16'h0064;
    cycle_model();
    cmp("t6_busy_pre", arb_busy, 1'b1);
    idle();
    cpu_rstn = 0;
    #1 cmp("t6_reset_outs", all_outs(), '0);
    model_reset();
    @(negedge cpu_clk);
    cpu_rstn = 1;
    @(negedge cpu_clk);
    dtcm_read_data_valid = 1; dtcm_read_data = 32'hDEAD_BEEF;
    #1 cmp("t6_stray", {c_read_data_valid, s_read_data_valid, arb_busy}, 3'b000);
    cycle_model();
    idle();

    // 5: continuous C writes against a waiting S write.
    got = -1;
    for (int k = 0; k < 40 && got < 0; k++) begin
      c_access = 1; c_rd0_wr1 = 1; c_addr = ADDR_WIDTH'(16'h0100 + k);
      s_access = 1; s_rd0_wr1 = 1; s_addr = 16'h0300;
      cycle_model();
      if (act_s_rdy) got = k;
    end
    s_access = 0;
`ifdef KRV_DTCM_ARB_BOOST_EN
    cmp("t5_boost_cycle", 128'(got), 128'(8));
    #1 cmp("t5_c_resume", c_ready, 1'b1);
    cycle_model();
`else
    cmp("t5_starve", 128'(got), 128'(-1));
`endif
    idle();
    cycle_model();

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      if (!c_access || m_c_acc) begin
        c_access = ($urandom_range(0, 2) != 0);
        c_rd0_wr1 = 1'($urandom_range(0, 1));
        c_byte_strobe = 4'($urandom);
        c_write_data = $urandom;
        c_addr = ADDR_WIDTH'($urandom);
      end
      if (!s_access || m_s_acc) begin
        s_access = ($urandom_range(0, 1) != 0);
        s_rd0_wr1 = 1'($urandom_range(0, 1));
        s_byte_strobe = 4'($urandom);
        s_write_data = $urandom;
        s_addr = ADDR_WIDTH'($urandom);
      end
      dtcm_ready = ($urandom_range(0, 3) != 0);
      dtcm_read_data_valid = (q_own.size() > 0) && ($urandom_range(0, 1) != 0);
      dtcm_read_data = $urandom;
      cycle_model();
    end
    drain();
    cycle_model();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
